// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time writer for the instruction memory. Accepts a framed byte stream
//   (0xA5, LEN_HI, LEN_LO, LEN*4 data bytes MSB first, optional CSUM), writes
//   big-endian 32-bit words to consecutive word addresses and holds the CPU in
//   reset until a complete image has been accepted.
//
//   Build option: IMEM_LOADER_CSUM_EN
//     defined   - a trailing CSUM byte (XOR of every byte after sync) is checked
//     undefined - no CSUM byte; the frame completes after the last data word
//
//   Ports
//     CLK, reset            clock, synchronous active-high reset
//     rx_data/valid/ready   byte stream handshake (transfer on valid & ready)
//     imem_we/addr/wdata    one-cycle instruction-memory write
//     cpu_resetn            active-low processor reset, released on done
//     done                  image loaded, sticky until reset
//     error                 frame rejected
//
//   state   | meaning
//   IDLE    | hunting for sync byte
//   LEN_HI  | expecting length high byte
//   LEN_LO  | expecting length low byte, range check
//   DATA    | assembling and writing words
//   CSUM    | expecting checksum byte (checksum build only)
//   DONE    | image loaded, stream closed
//   ERROR   | frame rejected, waiting for a new sync byte
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_resetn,
  output logic              done,
  output logic              error
);

  localparam logic [7:0]  SYNC    = 8'hA5;
  localparam logic [16:0] MAX_LEN = 17'(2 ** ADDR_W);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERROR
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          len_hi_q, len_hi_d;
  logic [15:0]         words_left_q, words_left_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [23:0]         shift_q, shift_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic                rx_ready_q, rx_ready_d;
  logic                imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic [31:0]         imem_wdata_q, imem_wdata_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  logic        hs;
  logic [15:0] len;

  assign hs  = rx_valid & rx_ready_q;
  assign len = {len_hi_q, rx_data};

  always_comb begin
    state_d      = state_q;
    len_hi_d     = len_hi_q;
    words_left_d = words_left_q;
    byte_cnt_d   = byte_cnt_q;
    shift_d      = shift_q;
    waddr_d      = waddr_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    done_d       = done_q;
`ifdef IMEM_LOADER_CSUM_EN
    csum_d       = csum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (hs && rx_data == SYNC) begin
          state_d = S_LEN_HI;
`ifdef IMEM_LOADER_CSUM_EN
          csum_d  = 8'h00;
`endif
        end
      end
      S_LEN_HI: begin
        if (hs) begin
          len_hi_d = rx_data;
          state_d  = S_LEN_LO;
`ifdef IMEM_LOADER_CSUM_EN
          csum_d   = csum_q ^ rx_data;
`endif
        end
      end
      S_LEN_LO: begin
        if (hs) begin
          words_left_d = len;
          byte_cnt_d   = 2'd0;
`ifdef IMEM_LOADER_CSUM_EN
          csum_d       = csum_q ^ rx_data;
`endif
          if ({1'b0, len} > MAX_LEN) begin
            state_d = S_ERROR;
          end else if (len == 16'd0) begin
`ifdef IMEM_LOADER_CSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (hs) begin
          shift_d    = {shift_q[15:0], rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CSUM_EN
          csum_d     = csum_q ^ rx_data;
`endif
          if (byte_cnt_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = waddr_q;
            imem_wdata_d = {shift_q, rx_data};
            waddr_d      = waddr_q + 1'b1;
            words_left_d = words_left_q - 16'd1;
            if (words_left_q == 16'd1) begin
`ifdef IMEM_LOADER_CSUM_EN
              state_d = S_CSUM;
`else
              state_d = S_DONE;
`endif
            end
          end
        end
      end
`ifdef IMEM_LOADER_CSUM_EN
      S_CSUM: begin
        if (hs) begin
          if (csum_q == rx_data) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERROR;
          end
        end
      end
`endif
      S_DONE: begin
        // Without a checksum byte, done follows one cycle after the last write.
        done_d = 1'b1;
      end
      S_ERROR: begin
        if (hs && rx_data == SYNC) begin
          state_d = S_LEN_HI;
          waddr_d = '0;
`ifdef IMEM_LOADER_CSUM_EN
          csum_d  = 8'h00;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    rx_ready_d = (state_d != S_DONE);
    error_d    = (state_d == S_ERROR);
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q      <= S_IDLE;
      len_hi_q     <= '0;
      words_left_q <= '0;
      byte_cnt_q   <= '0;
      shift_q      <= '0;
      waddr_q      <= '0;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      len_hi_q     <= len_hi_d;
      words_left_q <= words_left_d;
      byte_cnt_q   <= byte_cnt_d;
      shift_q      <= shift_d;
      waddr_q      <= waddr_d;
      rx_ready_q   <= rx_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      done_q       <= done_d;
      error_q      <= error_d;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign rx_ready   = rx_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign done       = done_q;
  assign cpu_resetn = done_q;  // the CPU is released exactly when the image is complete
  assign error      = error_q;

endmodule
